led_wrap_controller: RTL and testbench

//  Consumer end of the clock-divider interface: samples the divider's slow outclk

---
 rtl/led_pkg.sv | 22 ++
 rtl/tick_edge_sync.sv | 29 ++
 rtl/led_wrap_controller.sv | 116 +++++++++++
 tb/tb_led_wrap_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants for the LED pattern controller: mode codes, direction
// codes and the bounce FSM state encoding.
package led_pkg;

    localparam logic [1:0] MODE_WRAP   = 2'b00;
    localparam logic [1:0] MODE_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;

    localparam logic DIR_UP   = 1'b0;  // toward MSB
    localparam logic DIR_DOWN = 1'b1;  // toward LSB

    typedef enum logic {
        S_UP   = 1'b0,
        S_DOWN = 1'b1
    } bounce_state_e;

    // Both HOLD encodings (10 and 11) freeze the pattern.
    function automatic logic mode_moves(input logic [1:0] m);
        return (m == MODE_WRAP) || (m == MODE_BOUNCE);
    endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Brings the divider's slow clock level into the clk domain and turns each
// rising edge into a single-cycle step pulse.
module tick_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    output logic step
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    // Two-flop synchroniser followed by a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= tick_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign step = s2_q & ~prev_q;

endmodule

// File: rtl/led_wrap_controller.sv
// One-hot LED chaser driven by divider ticks, with wrap, bounce and hold modes.
module led_wrap_controller
    import led_pkg::*;
#(
    parameter int unsigned N_LEDS = 16,
    parameter int unsigned STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic [1:0]        mode,
    input  logic              dir,
    input  logic              pause,
    output logic [N_LEDS-1:0] led,
    output logic              wrap_pulse,
    output logic [STEP_W-1:0] step_cnt
);

    logic step;

    tick_edge_sync u_tick_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .step    (step)
    );

    logic [N_LEDS-1:0] led_q, led_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              pulse_q, pulse_d;
    logic [1:0]        mode_q;
    bounce_state_e     state_q, state_d;

    logic              entering;
    bounce_state_e     state_eff;
    logic              applied;
    logic              at_msb;
    logic              at_lsb;
    logic [N_LEDS-1:0] led_rol;
    logic [N_LEDS-1:0] led_ror;

    // Next-state logic: bounce entry, step qualification and pattern update.
    always_comb begin
        led_d    = led_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;

        // A fresh entry into BOUNCE picks its direction from dir; a step on
        // the same cycle already moves in that direction.
        entering  = (mode == MODE_BOUNCE) && (mode_q != MODE_BOUNCE);
        state_eff = entering ? ((dir == DIR_DOWN) ? S_DOWN : S_UP) : state_q;
        state_d   = state_eff;

        applied = step & ~pause & mode_moves(mode);
        at_msb  = led_q[N_LEDS-1];
        at_lsb  = led_q[0];
        led_rol = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
        led_ror = {led_q[0], led_q[N_LEDS-1:1]};

        if (applied) begin
            cnt_d = cnt_q + STEP_W'(1);
            if (mode == MODE_WRAP) begin
                if (dir == DIR_UP) begin
                    led_d   = led_rol;
                    pulse_d = at_msb;
                end else begin
                    led_d   = led_ror;
                    pulse_d = at_lsb;
                end
            end else begin
                unique case (state_eff)
                    S_UP: begin
                        if (at_msb) begin
                            led_d   = led_ror;
                            state_d = S_DOWN;
                            pulse_d = 1'b1;
                        end else begin
                            led_d = led_rol;
                        end
                    end
                    S_DOWN: begin
                        if (at_lsb) begin
                            led_d   = led_rol;
                            state_d = S_UP;
                            pulse_d = 1'b1;
                        end else begin
                            led_d = led_ror;
                        end
                    end
                endcase
            end
        end
    end

    // State registers; reset overrides any step on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q   <= {{(N_LEDS-1){1'b0}}, 1'b1};
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            mode_q  <= MODE_WRAP;
            state_q <= S_UP;
        end else begin
            led_q   <= led_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            mode_q  <= mode;
            state_q <= state_d;
        end
    end

    assign led        = led_q;
    assign wrap_pulse = pulse_q;
    assign step_cnt   = cnt_q;

endmodule

// File: tb/tb_led_wrap_controller.sv
// Self-checking bench for led_wrap_controller: directed table, hand-written
// corner sequences and randomized ticks against a position-based model.
module tb_led_wrap_controller;

    localparam int N = 16;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_in = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          dir = 1'b0;
    logic          pause = 1'b0;
    logic [N-1:0]  led;
    logic          wrap_pulse;
    logic [W-1:0]  step_cnt;

    led_wrap_controller #(
        .N_LEDS (N),
        .STEP_W (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .mode       (mode),
        .dir        (dir),
        .pause      (pause),
        .led        (led),
        .wrap_pulse (wrap_pulse),
        .step_cnt   (step_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt = 0;
    bit mon_en = 1'b0;
    logic pulse_prev = 1'b0;

    // Model: LED index, bounce heading, applied-step count, last mode driven.
    int       m_pos = 0;
    bit       m_up = 1'b1;
    int       m_cnt = 0;
    logic [1:0] m_mode = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Continuous checks: one-hot pattern and single-cycle wrap pulse.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("onehot", {31'd0, $onehot(led)}, 32'd1);
            if (wrap_pulse && pulse_prev) check("pulse_width", {31'd0, wrap_pulse}, 32'd0);
            if (wrap_pulse) pulse_cnt++;
            pulse_prev = wrap_pulse;
        end
    end

    task automatic model_reset();
        m_pos = 0; m_up = 1'b1; m_cnt = 0; m_mode = 2'b00;
    endtask

    task automatic do_reset();
        mode = 2'b00; dir = 1'b0; pause = 1'b0;
        rst = 1'b1;
        tick_in = 1'b1;
        @(posedge clk); #1;
        tick_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("rst_led", {16'd0, led}, 32'h0001);
        check("rst_cnt", {24'd0, step_cnt}, 32'd0);
        check("rst_pulse", {31'd0, wrap_pulse}, 32'd0);
    endtask

    task automatic set_ctrl(input logic [1:0] m, input logic d, input logic p);
        if (m == 2'b01 && m_mode != 2'b01) m_up = (d == 1'b0);
        m_mode = m;
        mode = m; dir = d; pause = p;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // One tick: high for hi edges, low for lo (>=3) edges, then model check.
    task automatic do_tick(input int hi, input int lo, output int pulses);
        int  pc0;
        int  exp_pulse;
        logic [N-1:0] e;
        pc0 = pulse_cnt;
        tick_in = 1'b1;
        repeat (hi) @(posedge clk);
        #1 tick_in = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
        pulses = pulse_cnt - pc0;
        exp_pulse = 0;
        if (!pause && (mode == 2'b00 || mode == 2'b01)) begin
            m_cnt = (m_cnt + 1) % 256;
            if (mode == 2'b00) begin
                if (dir == 1'b0) begin
                    exp_pulse = (m_pos == N - 1) ? 1 : 0;
                    m_pos = (m_pos + 1) % N;
                end else begin
                    exp_pulse = (m_pos == 0) ? 1 : 0;
                    m_pos = (m_pos + N - 1) % N;
                end
            end else if (m_up) begin
                if (m_pos == N - 1) begin
                    m_pos = N - 2; m_up = 1'b0; exp_pulse = 1;
                end else m_pos = m_pos + 1;
            end else begin
                if (m_pos == 0) begin
                    m_pos = 1; m_up = 1'b1; exp_pulse = 1;
                end else m_pos = m_pos - 1;
            end
        end
        e = 16'h0001 << m_pos;
        check("model_led", {16'd0, led}, {16'd0, e});
        check("model_cnt", {24'd0, step_cnt}, m_cnt);
        check("model_pulse", pulses, exp_pulse);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic        dir;
        logic        pause;
        logic [15:0] led;
        logic [7:0]  cnt;
        int          pulses;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int pc;
        vecs[0]  = '{2'b00, 1'b1, 1'b0, 16'h8000, 8'd1,  1};
        vecs[1]  = '{2'b00, 1'b1, 1'b0, 16'h4000, 8'd2,  0};
        vecs[2]  = '{2'b01, 1'b0, 1'b0, 16'h8000, 8'd3,  0};
        vecs[3]  = '{2'b01, 1'b0, 1'b0, 16'h4000, 8'd4,  1};
        vecs[4]  = '{2'b01, 1'b1, 1'b0, 16'h2000, 8'd5,  0};
        vecs[5]  = '{2'b01, 1'b1, 1'b1, 16'h2000, 8'd5,  0};
        vecs[6]  = '{2'b10, 1'b0, 1'b0, 16'h2000, 8'd5,  0};
        vecs[7]  = '{2'b11, 1'b1, 1'b0, 16'h2000, 8'd5,  0};
        vecs[8]  = '{2'b00, 1'b0, 1'b0, 16'h4000, 8'd6,  0};
        vecs[9]  = '{2'b00, 1'b1, 1'b0, 16'h2000, 8'd7,  0};
        vecs[10] = '{2'b01, 1'b1, 1'b0, 16'h1000, 8'd8,  0};
        vecs[11] = '{2'b00, 1'b0, 1'b0, 16'h2000, 8'd9,  0};
        vecs[12] = '{2'b01, 1'b0, 1'b0, 16'h4000, 8'd10, 0};

        @(posedge clk); #1;
        mon_en = 1'b1;

        // Reset with tick toggling, then a full WRAP lap toward MSB.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            logic [15:0] e;
            do_tick(1 + (i % 3), 3, pc);
            e = 16'h0001 << ((i + 1) % 16);
            check("wrap_lap_led", {16'd0, led}, {16'd0, e});
            check("wrap_lap_pulse", pc, (i == 15) ? 1 : 0);
        end
        check("wrap_lap_cnt", {24'd0, step_cnt}, 32'd16);
        do_tick(50, 4, pc);
        check("held_tick_led", {16'd0, led}, 32'h0002);
        check("held_tick_cnt", {24'd0, step_cnt}, 32'd17);

        // Directed table: WRAP down, bounce entry/reversal, pause, hold.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            set_ctrl(vecs[i].mode, vecs[i].dir, vecs[i].pause);
            do_tick(2, 4, pc);
            check("tbl_led", {16'd0, led}, {16'd0, vecs[i].led});
            check("tbl_cnt", {24'd0, step_cnt}, {24'd0, vecs[i].cnt});
            check("tbl_pulse", pc, vecs[i].pulses);
        end

        // Reset landing on the edge that would apply a step at 0x0100.
        do_reset();
        for (int i = 0; i < 8; i++) do_tick(1, 3, pc);
        check("pre_rst_led", {16'd0, led}, 32'h0100);
        tick_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        tick_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check("step_rst_led", {16'd0, led}, 32'h0001);
        check("step_rst_cnt", {24'd0, step_cnt}, 32'd0);
        check("step_rst_pulse", {31'd0, wrap_pulse}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_hold", {16'd0, led}, 32'h0001);
        do_tick(1, 3, pc);
        check("post_rst_led", {16'd0, led}, 32'h0002);

        // Randomized controls and tick shapes against the model.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                int r;
                logic [1:0] m;
                r = $urandom_range(0, 9);
                m = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
                set_ctrl(m, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
            end
            do_tick($urandom_range(1, 6), $urandom_range(3, 6), pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
